// File: rtl/cpu_sequencer.sv
// Phase sequencer and control-strobe decoder for the 8-bit accumulator CPU.
// Adds memory wait states, a sticky halt with resume, and a retired-instruction counter.

package typedefs;
   typedef enum logic [7:0] {
      INST_ADDR  = 8'd0,
      INST_FETCH = 8'd1,
      INST_LOAD  = 8'd2,
      IDLE       = 8'd3,
      OP_ADDR    = 8'd4,
      OP_FETCH   = 8'd5,
      ALU_OP     = 8'd6,
      STORE      = 8'd7
   } state_t;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcodes_t;
endpackage

module cpu_sequencer
   import typedefs::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  opcodes_t         opcode,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             resume,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             halt,
   output logic             inc_pc,
   output logic             ld_ac,
   output logic             ld_pc,
   output logic             wr,
   output logic             data_e,
   output state_t           state,
   output logic [CNT_W-1:0] instr_count
);

   state_t next_state;
   logic   count_en;
   logic   is_aluop;
   logic   is_sto;
   logic   is_jmp;
   logic   is_skz;
   logic   is_hlt;

   assign is_aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
   assign is_sto   = (opcode == STO);
   assign is_jmp   = (opcode == JMP);
   assign is_skz   = (opcode == SKZ);
   assign is_hlt   = (opcode == HLT);

   // Phase register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INST_ADDR;
      end else begin
         state <= next_state;
      end
   end

   // Next phase and strobe decode; a phase holds while its memory access or halt is pending
   always_comb begin
      next_state = state;
      count_en   = 1'b0;
      sel        = 1'b0;
      rd         = 1'b0;
      ld_ir      = 1'b0;
      halt       = 1'b0;
      inc_pc     = 1'b0;
      ld_ac      = 1'b0;
      ld_pc      = 1'b0;
      wr         = 1'b0;
      data_e     = 1'b0;

      case (state)
         INST_ADDR: begin
            sel        = 1'b1;
            next_state = INST_FETCH;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
            if (mem_ready) begin
               next_state = INST_LOAD;
            end
         end
         INST_LOAD: begin
            sel        = 1'b1;
            rd         = 1'b1;
            ld_ir      = 1'b1;
            next_state = IDLE;
         end
         IDLE: begin
            sel        = 1'b1;
            rd         = 1'b1;
            ld_ir      = 1'b1;
            next_state = OP_ADDR;
         end
         OP_ADDR: begin
            if (is_hlt) begin
               halt   = 1'b1;
               inc_pc = resume;
               if (resume) begin
                  next_state = OP_FETCH;
               end
            end else begin
               inc_pc     = 1'b1;
               next_state = OP_FETCH;
            end
         end
         OP_FETCH: begin
            rd = is_aluop;
            if (!is_aluop || mem_ready) begin
               next_state = ALU_OP;
            end
         end
         ALU_OP: begin
            rd         = is_aluop;
            inc_pc     = is_skz && zero;
            ld_pc      = is_jmp;
            data_e     = is_sto;
            next_state = STORE;
         end
         STORE: begin
            rd     = is_aluop;
            ld_ac  = is_aluop;
            inc_pc = is_jmp;
            ld_pc  = is_jmp;
            wr     = is_sto;
            data_e = is_sto;
            if (!is_sto || mem_ready) begin
               next_state = INST_ADDR;
               count_en   = 1'b1;
            end
         end
         default: begin
            // Unused encodings decode as INST_ADDR
            sel        = 1'b1;
            next_state = INST_FETCH;
         end
      endcase
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
      end else if (count_en) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer against a per-phase behavioural model.
// A second instance with a 4-bit counter shares all stimulus to exercise wrap-around.

module tb_cpu_sequencer;
   import typedefs::*;

   logic        clk;
   logic        rst_n;
   opcodes_t    opcode;
   logic        zero;
   logic        mem_ready;
   logic        resume;

   logic        sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
   state_t      state;
   logic [15:0] instr_count;

   logic        sel4, rd4, ld_ir4, halt4, inc_pc4, ld_ac4, ld_pc4, wr4, data_e4;
   state_t      state4;
   logic [3:0]  instr_count4;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt16   = 0;
   int cnt4    = 0;
   int inc_pulses;
   int ldpc_pulses;

   cpu_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .resume(resume),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
      .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
      .state(state), .instr_count(instr_count)
   );

   cpu_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .resume(resume),
      .sel(sel4), .rd(rd4), .ld_ir(ld_ir4), .halt(halt4), .inc_pc(inc_pc4),
      .ld_ac(ld_ac4), .ld_pc(ld_pc4), .wr(wr4), .data_e(data_e4),
      .state(state4), .instr_count(instr_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} from the phase table
   function automatic logic [8:0] exp_strobes(input state_t ph, input opcodes_t op,
                                              input logic z, input logic res);
      logic alu;
      logic [8:0] s;
      alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      s = '0;
      case (ph)
         INST_ADDR:  s = 9'b1_0000_0000;
         INST_FETCH: s = 9'b1_1000_0000;
         INST_LOAD:  s = 9'b1_1100_0000;
         IDLE:       s = 9'b1_1100_0000;
         OP_ADDR:    s = (op == HLT) ? {4'b0001, res, 4'b0000} : 9'b0_0001_0000;
         OP_FETCH:   s = {1'b0, alu, 7'b0};
         ALU_OP:     s = {1'b0, alu, 2'b00, (op == SKZ) && z, 1'b0, op == JMP, 1'b0, op == STO};
         STORE:      s = {1'b0, alu, 2'b00, op == JMP, alu, op == JMP, op == STO, op == STO};
         default:    s = 9'b1_0000_0000;
      endcase
      return s;
   endfunction

   task automatic check_outputs(input state_t ph, input opcodes_t op, input logic z, input logic res);
      check("state", 32'(state), 32'(ph));
      check("strobes", 32'({sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}),
            32'(exp_strobes(ph, op, z, res)));
      check("state_w4", 32'(state4), 32'(ph));
      check("strobes_w4", 32'({sel4, rd4, ld_ir4, halt4, inc_pc4, ld_ac4, ld_pc4, wr4, data_e4}),
            32'(exp_strobes(ph, op, z, res)));
      check("count16", 32'(instr_count), 32'(cnt16));
      check("count4", 32'(instr_count4), 32'(cnt4));
   endtask

   // One clock cycle: drive at the falling edge, compare 1 time unit later, wait for the next falling edge
   task automatic cyc(input state_t ph, input logic mr, input logic res, input opcodes_t op, input logic z);
      opcode = op; zero = z; mem_ready = mr; resume = res;
      #1;
      check_outputs(ph, op, z, res);
      if (inc_pc) inc_pulses++;
      if (ld_pc) ldpc_pulses++;
      @(negedge clk);
   endtask

   // Reset asserted in the middle of a held cycle; both counters return to zero at once
   task automatic reset_mid(input state_t ph, input logic mr, input logic res, input opcodes_t op, input logic z);
      opcode = op; zero = z; mem_ready = mr; resume = res;
      #1;
      check_outputs(ph, op, z, res);
      #1 rst_n = 1'b0;
      cnt16 = 0;
      cnt4  = 0;
      #1;
      check_outputs(INST_ADDR, op, z, res);
      check("rst_wr", 32'(wr), 32'd0);
      check("rst_data_e", 32'(data_e), 32'd0);
      @(negedge clk);
      check("rst_hold_state", 32'(state), 32'(INST_ADDR));
      rst_n = 1'b1;
   endtask

   function automatic opcodes_t rand_op();
      return opcodes_t'($urandom_range(0, 7));
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One instruction; wf/wo/ws = wait cycles, wh = halt cycles before resume, abort_at = hold cycle to reset in
   task automatic instr(input opcodes_t op, input logic z, input int wf, input int wo,
                        input int ws, input int wh, input int abort_at);
      logic alu;
      alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      inc_pulses  = 0;
      ldpc_pulses = 0;
      cyc(INST_ADDR, rbit(), rbit(), rand_op(), rbit());
      for (int i = 0; i < wf; i++) cyc(INST_FETCH, 1'b0, rbit(), rand_op(), rbit());
      cyc(INST_FETCH, 1'b1, rbit(), rand_op(), rbit());
      cyc(INST_LOAD, rbit(), rbit(), rand_op(), rbit());
      cyc(IDLE, rbit(), rbit(), op, z);
      if (op == HLT) begin
         for (int i = 0; i < wh; i++) begin
            if (i == abort_at) begin
               reset_mid(OP_ADDR, rbit(), 1'b0, op, z);
               return;
            end
            cyc(OP_ADDR, rbit(), 1'b0, op, z);
         end
         cyc(OP_ADDR, rbit(), 1'b1, op, z);
      end else begin
         cyc(OP_ADDR, rbit(), rbit(), op, z);
      end
      if (alu) begin
         for (int i = 0; i < wo; i++) cyc(OP_FETCH, 1'b0, rbit(), op, z);
         cyc(OP_FETCH, 1'b1, rbit(), op, z);
      end else begin
         cyc(OP_FETCH, rbit(), rbit(), op, z);
      end
      cyc(ALU_OP, rbit(), rbit(), op, z);
      if (op == STO) begin
         for (int i = 0; i < ws; i++) begin
            if (i == abort_at) begin
               reset_mid(STORE, 1'b0, rbit(), op, z);
               return;
            end
            cyc(STORE, 1'b0, rbit(), op, z);
         end
         cyc(STORE, 1'b1, rbit(), op, z);
      end else begin
         cyc(STORE, rbit(), rbit(), op, z);
      end
      cnt16 = (cnt16 + 1) % 65536;
      cnt4  = (cnt4 + 1) % 16;
   endtask

   initial begin
      rst_n = 1'b0; opcode = HLT; zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
      #1;
      check_outputs(INST_ADDR, HLT, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      instr(ADD, 1'b0, 0, 0, 0, 0, -1);
      check("add_retired", 32'(instr_count), 32'd1);
      instr(STO, 1'b1, 0, 0, 3, 0, -1);
      check("sto_retired", 32'(instr_count), 32'd2);
      instr(SKZ, 1'b1, 0, 0, 0, 0, -1);
      check("skz_z1_inc_pc", 32'(inc_pulses), 32'd2);
      instr(SKZ, 1'b0, 0, 0, 0, 0, -1);
      check("skz_z0_inc_pc", 32'(inc_pulses), 32'd1);
      instr(JMP, 1'b0, 0, 0, 0, 0, -1);
      check("jmp_ld_pc", 32'(ldpc_pulses), 32'd2);
      check("jmp_inc_pc", 32'(inc_pulses), 32'd2);
      instr(HLT, 1'b0, 0, 0, 0, 5, -1);
      check("hlt_inc_pc", 32'(inc_pulses), 32'd1);
      instr(STO, 1'b0, 2, 0, 3, 0, 1);
      check("abort_store_count", 32'(instr_count), 32'd0);
      instr(HLT, 1'b1, 0, 0, 0, 4, 2);
      check("abort_halt_count", 32'(instr_count), 32'd0);

      for (int n = 0; n < 60; n++) begin
         instr(rand_op(), rbit(), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end
      check("final_count16", 32'(instr_count), 32'd60);
      check("final_count4", 32'(instr_count4), 32'(60 % 16));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
